// File: rtl/khazad_pkg.sv
// Shared constants and the sequencer state type for the KHAZAD mode sequencer.
package khazad_pkg;

    localparam int BLOCK_W = 64;
    localparam int KEY_W   = 128;
    localparam int ROUNDS  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KEY  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } seq_state_t;

endpackage

// File: rtl/khazad_chain_reg.sv
// Chaining datapath for the mode sequencer: holds the CBC chain value,
// forms the block presented to the round core and the result block.
module khazad_chain_reg #(
    parameter int BLOCK_W = khazad_pkg::BLOCK_W
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               i_seed,
    input  logic               i_update,
    input  logic               i_cbc,
    input  logic               i_dec,
    input  logic [BLOCK_W-1:0] i_iv,
    input  logic [BLOCK_W-1:0] i_block,
    input  logic [BLOCK_W-1:0] i_core_out,
    output logic [BLOCK_W-1:0] o_core_in,
    output logic [BLOCK_W-1:0] o_data_out
);

    logic [BLOCK_W-1:0] r_chain;
    logic [BLOCK_W-1:0] r_data_out;
    logic [BLOCK_W-1:0] w_chain_nxt;
    logic [BLOCK_W-1:0] w_result;
    logic               w_cbc_enc;
    logic               w_cbc_dec;

    assign w_cbc_enc = i_cbc & ~i_dec;
    assign w_cbc_dec = i_cbc &  i_dec;

    // Encrypt-side whitening with the chain happens before the core.
    assign o_core_in = w_cbc_enc ? (i_block ^ r_chain) : i_block;

    // Decrypt-side whitening with the chain happens after the core.
    assign w_result = w_cbc_dec ? (i_core_out ^ r_chain) : i_core_out;

    // Chain value selection: a completed CBC block advances it, a new first block seeds it.
    always_comb begin
        w_chain_nxt = r_chain;
        if (i_update) begin
            if (w_cbc_enc) begin
                w_chain_nxt = i_core_out;
            end else if (w_cbc_dec) begin
                w_chain_nxt = i_block;
            end
        end else if (i_seed) begin
            w_chain_nxt = i_iv;
        end
    end

    // Chain register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_chain <= '0;
        end else begin
            r_chain <= w_chain_nxt;
        end
    end

    // Result register; holds until the next completed block.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_data_out <= '0;
        end else if (i_update) begin
            r_data_out <= w_result;
        end
    end

    assign o_data_out = r_data_out;

endmodule

// File: rtl/khazad_mode_sequencer.sv
// Sequences one KHAZAD block operation per start pulse: optional key load,
// one pass through the round core, ECB/CBC chaining, one-cycle finish.
//
//   state | meaning
//   IDLE  | waiting for start
//   KEY   | key schedule expanding key_out, waiting for key_done
//   RUN   | round core busy on core_in, waiting for core_done
//   DONE  | finish pulse, result on data_out
module khazad_mode_sequencer #(
    parameter int BLOCK_W = khazad_pkg::BLOCK_W,
    parameter int KEY_W   = khazad_pkg::KEY_W
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic               only_data,
    input  logic               enc_dec_SEL,
    input  logic               op_mode,
    input  logic               first_block,
    input  logic [BLOCK_W-1:0] data_in,
    input  logic [KEY_W-1:0]   key_in,
    input  logic [BLOCK_W-1:0] iv_in,
    output logic               key_start,
    output logic [KEY_W-1:0]   key_out,
    input  logic               key_done,
    output logic               core_start,
    output logic               core_dec,
    output logic [BLOCK_W-1:0] core_in,
    input  logic [BLOCK_W-1:0] core_out,
    input  logic               core_done,
    output logic [BLOCK_W-1:0] data_out,
    output logic               finish,
    output logic               busy
);

    import khazad_pkg::*;

    seq_state_t         r_state;
    seq_state_t         w_state_nxt;

    logic [BLOCK_W-1:0] r_block;
    logic               r_cbc;
    logic               r_core_dec;
    logic [KEY_W-1:0]   r_key_out;
    logic               r_key_valid;
    logic               r_key_start;
    logic               r_core_start;
    logic               r_finish;
    logic               r_busy;

    logic               w_need_key;
    logic               w_accept;
    logic               w_key_load;
    logic               w_key_ack;
    logic               w_core_fire;
    logic               w_key_start_nxt;
    logic               w_core_start_nxt;
    logic               w_finish_nxt;

    // With no valid key loaded, a reuse request still has to load one.
    assign w_need_key = ~only_data | ~r_key_valid;

    // Next-state decode; pulse outputs are computed here and registered below.
    always_comb begin
        w_state_nxt      = r_state;
        w_accept         = 1'b0;
        w_key_load       = 1'b0;
        w_key_ack        = 1'b0;
        w_core_fire      = 1'b0;
        w_key_start_nxt  = 1'b0;
        w_core_start_nxt = 1'b0;
        w_finish_nxt     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    if (w_need_key) begin
                        w_key_load      = 1'b1;
                        w_key_start_nxt = 1'b1;
                        w_state_nxt     = KEY;
                    end else begin
                        w_core_start_nxt = 1'b1;
                        w_state_nxt      = RUN;
                    end
                end
            end
            KEY: begin
                if (key_done) begin
                    w_key_ack        = 1'b1;
                    w_core_start_nxt = 1'b1;
                    w_state_nxt      = RUN;
                end
            end
            RUN: begin
                if (core_done) begin
                    w_core_fire  = 1'b1;
                    w_finish_nxt = 1'b1;
                    w_state_nxt  = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register and registered control pulses.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= IDLE;
            r_key_start  <= 1'b0;
            r_core_start <= 1'b0;
            r_finish     <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_key_start  <= w_key_start_nxt;
            r_core_start <= w_core_start_nxt;
            r_finish     <= w_finish_nxt;
            r_busy       <= (w_state_nxt != IDLE);
        end
    end

    // Op registers, captured only when an operation is accepted.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_block    <= '0;
            r_cbc      <= 1'b0;
            r_core_dec <= 1'b0;
        end else if (w_accept) begin
            r_block    <= data_in;
            r_cbc      <= op_mode;
            r_core_dec <= ~enc_dec_SEL;
        end
    end

    // Key register and its validity flag; valid only after the schedule confirms.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_key_out   <= '0;
            r_key_valid <= 1'b0;
        end else begin
            if (w_key_load) begin
                r_key_out <= key_in;
            end
            if (w_key_ack) begin
                r_key_valid <= 1'b1;
            end
        end
    end

    khazad_chain_reg #(
        .BLOCK_W (BLOCK_W)
    ) u_chain (
        .CLK        (CLK),
        .RST        (RST),
        .i_seed     (w_accept & first_block),
        .i_update   (w_core_fire),
        .i_cbc      (r_cbc),
        .i_dec      (r_core_dec),
        .i_iv       (iv_in),
        .i_block    (r_block),
        .i_core_out (core_out),
        .o_core_in  (core_in),
        .o_data_out (data_out)
    );

    assign key_start  = r_key_start;
    assign key_out    = r_key_out;
    assign core_start = r_core_start;
    assign core_dec   = r_core_dec;
    assign finish     = r_finish;
    assign busy       = r_busy;

endmodule

// File: tb/tb_khazad_mode_sequencer.sv
// Self-checking bench for khazad_mode_sequencer with mock key schedule and core.
module tb_khazad_mode_sequencer;

    localparam logic [63:0] MASK = 64'h5A5A5A5A5A5A5A5A;
    localparam logic [127:0] K1 = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] K2 = 128'hFEDCBA98765432100F1E2D3C4B5A6978;

    logic          CLK = 1'b0;
    logic          RST;
    logic          start, only_data, enc_dec_SEL, op_mode, first_block;
    logic [63:0]   data_in, iv_in;
    logic [127:0]  key_in;
    logic          key_start, key_done, core_start, core_dec, core_done, finish, busy;
    logic [127:0]  key_out;
    logic [63:0]   core_in, core_out, data_out;

    logic          mock_kd, mock_cd, inj_kd, inj_cd;
    int            lkey, lcore;
    int            mk_rem, mc_rem;
    logic [63:0]   mc_lat_in;

    int            n_checks = 0;
    int            n_fail   = 0;

    // behavioural model state
    logic          m_key_valid;
    logic [63:0]   m_chain;
    logic [127:0]  m_key;

    assign key_done  = mock_kd | inj_kd;
    assign core_done = mock_cd | inj_cd;

    always #5 CLK = ~CLK;

    khazad_mode_sequencer dut (
        .CLK(CLK), .RST(RST), .start(start), .only_data(only_data),
        .enc_dec_SEL(enc_dec_SEL), .op_mode(op_mode), .first_block(first_block),
        .data_in(data_in), .key_in(key_in), .iv_in(iv_in),
        .key_start(key_start), .key_out(key_out), .key_done(key_done),
        .core_start(core_start), .core_dec(core_dec), .core_in(core_in),
        .core_out(core_out), .core_done(core_done), .data_out(data_out),
        .finish(finish), .busy(busy)
    );

    // Mock key schedule and round core: done pulses arrive lkey / lcore cycles after the start pulse.
    initial begin
        mk_rem = 0; mc_rem = 0; mock_kd = 1'b0; mock_cd = 1'b0;
        core_out = '0; mc_lat_in = '0;
        forever begin
            @(posedge CLK); #1;
            mock_kd = 1'b0;
            mock_cd = 1'b0;
            if (mk_rem > 0) begin
                mk_rem--;
                if (mk_rem == 0) mock_kd = 1'b1;
            end
            if (mc_rem > 0) begin
                mc_rem--;
                if (mc_rem == 0) begin
                    mock_cd  = 1'b1;
                    core_out = mc_lat_in ^ MASK;
                end
            end
            if (key_start === 1'b1) mk_rem = lkey;
            if (core_start === 1'b1) begin
                mc_rem    = lcore;
                mc_lat_in = core_in;
            end
        end
    end

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_key_valid = 1'b0;
        m_chain     = '0;
        m_key       = '0;
    endtask

    // Reference: what one operation should produce, from the mode rules.
    task automatic model_op(input logic od, input logic enc, input logic cbc, input logic first,
                            input logic [63:0] data, input logic [127:0] key, input logic [63:0] iv,
                            output logic [63:0] e_do, output logic [63:0] e_ci,
                            output int e_ks, output int e_lat);
        logic        load;
        logic [63:0] co;
        load = !od || !m_key_valid;
        if (load) begin
            m_key       = key;
            m_key_valid = 1'b1;
        end
        if (first) m_chain = iv;
        e_ci = (cbc && enc) ? (data ^ m_chain) : data;
        co   = e_ci ^ MASK;
        e_do = (cbc && !enc) ? (co ^ m_chain) : co;
        if (cbc) m_chain = enc ? co : data;
        e_ks  = load ? 1 : 0;
        e_lat = load ? (lkey + lcore + 3) : (lcore + 2);
    endtask

    // Issues one start and follows the operation up to its finish cycle.
    task automatic run_op(input logic od, input logic enc, input logic cbc, input logic first,
                          input logic [63:0] data, input logic [127:0] key, input logic [63:0] iv,
                          output int n_ks, output logic [63:0] ci_seen, output int lat,
                          output logic to);
        start = 1'b1; only_data = od; enc_dec_SEL = enc; op_mode = cbc;
        first_block = first; data_in = data; key_in = key; iv_in = iv;
        tick();
        start = 1'b0;
        n_ks = 0; ci_seen = 'x; lat = 1; to = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (key_start) n_ks++;
            if (core_start) ci_seen = core_in;
            if (finish) begin
                to = 1'b0;
                break;
            end
            tick();
            lat++;
        end
    endtask

    task automatic do_op(input string nm, input logic od, input logic enc, input logic cbc,
                         input logic first, input logic [63:0] data, input logic [127:0] key,
                         input logic [63:0] iv, input logic [63:0] e_do, input logic [63:0] e_ci,
                         input int e_ks, input int e_lat, input logic e_dec,
                         input logic [127:0] e_key);
        int          n_ks, lat;
        logic [63:0] ci;
        logic        to;
        run_op(od, enc, cbc, first, data, key, iv, n_ks, ci, lat, to);
        chk({nm, " finish_timeout"}, to, 1'b0);
        chk({nm, " data_out"}, data_out, e_do);
        chk({nm, " core_in"}, ci, e_ci);
        chk({nm, " key_start_count"}, n_ks, e_ks);
        chk({nm, " latency"}, lat, e_lat);
        chk({nm, " core_dec"}, core_dec, e_dec);
        chk({nm, " key_out"}, key_out, e_key);
        tick();
        chk({nm, " finish_one_cycle"}, {finish, busy}, 2'b00);
    endtask

    typedef struct {
        logic         od, enc, cbc, first;
        logic [63:0]  data;
        logic [127:0] key;
        logic [63:0]  iv;
        logic [63:0]  e_do, e_ci;
        int           e_ks, e_lat;
        logic         e_dec;
        logic [127:0] e_key;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [63:0]  mdo, mci, da, db, dc, iv_r;
        logic [127:0] kr;
        int           mks, mlat, fin, nks;
        logic         od, enc, cbc, first;

        // od enc cbc first data key iv | data_out core_in key_starts latency core_dec key_out
        tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 64'h0123456789ABCDEF, K1, 64'h0,
                   64'h5B791F3DD3F197B5, 64'h0123456789ABCDEF, 1, 16, 1'b0, K1};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 64'h0, K2, 64'h0,
                   64'h5A5A5A5A5A5A5A5A, 64'h0, 0, 11, 1'b0, K1};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 64'h0, K2, 64'hFFFFFFFFFFFFFFFF,
                   64'hA5A5A5A5A5A5A5A5, 64'hFFFFFFFFFFFFFFFF, 0, 11, 1'b0, K1};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 64'h0, K2, 64'h0,
                   64'hFFFFFFFFFFFFFFFF, 64'hA5A5A5A5A5A5A5A5, 0, 11, 1'b0, K1};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 64'hA5A5A5A5A5A5A5A5, K2, 64'hFFFFFFFFFFFFFFFF,
                   64'h0, 64'hA5A5A5A5A5A5A5A5, 1, 16, 1'b1, K2};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 64'hFFFFFFFFFFFFFFFF, K1, 64'h0,
                   64'h0, 64'hFFFFFFFFFFFFFFFF, 0, 11, 1'b1, K2};

        RST = 1'b1; start = 1'b0; only_data = 1'b0; enc_dec_SEL = 1'b0; op_mode = 1'b0;
        first_block = 1'b0; data_in = '0; key_in = '0; iv_in = '0;
        inj_kd = 1'b0; inj_cd = 1'b0; lkey = 4; lcore = 9;
        model_reset();
        repeat (3) tick();
        RST = 1'b0;
        tick();

        chk("reset pulses", {key_start, core_start, finish, busy}, 4'b0000);
        chk("reset data_out", data_out, 64'h0);
        chk("reset key_out", key_out, 128'h0);
        chk("reset core_dec", core_dec, 1'b0);

        // Stray downstream pulses while idle are ignored.
        inj_kd = 1'b1; tick(); inj_kd = 1'b0;
        inj_cd = 1'b1; tick(); inj_cd = 1'b0;
        tick();
        chk("stray pulses idle", {key_start, core_start, finish, busy}, 4'b0000);
        chk("stray pulses data_out", data_out, 64'h0);

        foreach (tbl[i]) begin
            model_op(tbl[i].od, tbl[i].enc, tbl[i].cbc, tbl[i].first, tbl[i].data,
                     tbl[i].key, tbl[i].iv, mdo, mci, mks, mlat);
            do_op($sformatf("vec%0d", i), tbl[i].od, tbl[i].enc, tbl[i].cbc, tbl[i].first,
                  tbl[i].data, tbl[i].key, tbl[i].iv, tbl[i].e_do, tbl[i].e_ci,
                  tbl[i].e_ks, tbl[i].e_lat, tbl[i].e_dec, tbl[i].e_key);
        end

        // A start arriving while RUN is in progress must not disturb the operation.
        da = 64'h1122334455667788;
        db = 64'hCAFEBABEDEADBEEF;
        model_op(1'b1, 1'b1, 1'b0, 1'b0, da, K1, 64'h0, mdo, mci, mks, mlat);
        start = 1'b1; only_data = 1'b1; enc_dec_SEL = 1'b1; op_mode = 1'b0;
        first_block = 1'b0; data_in = da; key_in = K1;
        tick();
        start = 1'b0;
        fin = 0; nks = 0;
        for (int i = 1; i < 25; i++) begin
            if (finish) fin++;
            if (key_start) nks++;
            if (i == 3) begin
                start = 1'b1; only_data = 1'b0; enc_dec_SEL = 1'b0; op_mode = 1'b1;
                first_block = 1'b1; data_in = db; key_in = K1; iv_in = 64'h0F0F0F0F0F0F0F0F;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        chk("ignored start finish_count", fin, 1);
        chk("ignored start key_starts", nks, 0);
        chk("ignored start data_out", data_out, mdo);
        chk("ignored start core_in", core_in, da);
        chk("ignored start core_dec", core_dec, 1'b0);
        chk("ignored start key_out", key_out, m_key);

        // Reset in the middle of RUN; the late core_done must be dropped.
        start = 1'b1; only_data = 1'b1; enc_dec_SEL = 1'b1; op_mode = 1'b1;
        first_block = 1'b0; data_in = da;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("mid-run busy", busy, 1'b1);
        RST = 1'b1; tick(); RST = 1'b0;
        model_reset();
        fin = 0;
        for (int i = 0; i < 20; i++) begin
            if (finish || busy) fin++;
            tick();
        end
        chk("post reset no finish", fin, 0);
        chk("post reset outputs", {key_start, core_start, finish, busy, core_dec}, 5'b00000);
        chk("post reset data_out", data_out, 64'h0);
        chk("post reset key_out", key_out, 128'h0);

        // First op after reset: reuse request still loads the key, chain starts at zero.
        dc = 64'h0246813579BDF0AC;
        model_op(1'b1, 1'b1, 1'b1, 1'b0, dc, K2, 64'h0, mdo, mci, mks, mlat);
        do_op("forced key load", 1'b1, 1'b1, 1'b1, 1'b0, dc, K2, 64'h0,
              mdo, dc, 1, lkey + lcore + 3, 1'b0, K2);
        model_op(1'b1, 1'b0, 1'b0, 1'b0, dc, K1, 64'h0, mdo, mci, mks, mlat);
        do_op("key reuse after load", 1'b1, 1'b0, 1'b0, 1'b0, dc, K1, 64'h0,
              mdo, mci, 0, lcore + 2, 1'b1, K2);

        // Randomized operations against the reference model.
        for (int n = 0; n < 40; n++) begin
            lcore = $urandom_range(2, 12);
            lkey  = $urandom_range(2, 8);
            od    = ($urandom_range(0, 3) != 0);
            enc   = $urandom_range(0, 1);
            cbc   = $urandom_range(0, 1);
            first = ($urandom_range(0, 3) == 0);
            da    = {$urandom, $urandom};
            iv_r  = {$urandom, $urandom};
            kr    = {$urandom, $urandom, $urandom, $urandom};
            model_op(od, enc, cbc, first, da, kr, iv_r, mdo, mci, mks, mlat);
            do_op($sformatf("rnd%0d", n), od, enc, cbc, first, da, kr, iv_r,
                  mdo, mci, mks, mlat, !enc, m_key);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
